kypd_entry_ctrl: RTL and testbench

//  Sequences the keypad decoder's 16-bit button vector into numeric entries.
//  - Synchronises and debounces the vector, then turns clean single-key presses into key events.
//  - Keys 0..D are digits, E is backspace and F is enter.
//  - Accumulates up to DIGITS digits and hands the finished value downstream over a valid/ready pair.
//  - Sits between the keypad decoder and application logic (display, command parser).

---
 rtl/kypd_pkg.sv | 33 +++
 rtl/kypd_debounce.sv | 61 ++++++
 rtl/kypd_entry_ctrl.sv | 144 ++++++++++++++
 tb/tb_kypd_entry_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kypd_pkg.sv
// kypd_pkg: shared key codes, press-FSM state type and key-vector helpers
// rev 1.0
`default_nettype none

package kypd_pkg;

  localparam logic [3:0] KEY_BACK    = 4'hE;
  localparam logic [3:0] KEY_ENTER   = 4'hF;
  localparam logic [3:0] KEY_MAX_DEC = 4'h9;
  localparam logic [3:0] KEY_MAX_HEX = 4'hD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    JAM   = 2'd2
  } press_state_e;

  function automatic logic [3:0] onehot_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/kypd_debounce.sv
// kypd_debounce: 2-flop synchroniser plus stable-sample counter for a W-bit vector
// rev 1.0
`default_nettype none

module kypd_debounce #(
  parameter int W         = 16,
  parameter int DB_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         dout_upd
);

  localparam int            CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);

  logic [W-1:0]  sync1_q, sync2_q, prev_q, dout_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          upd_q, upd_d;
  logic          changed;

  // The first sample of a new value already counts as one, so the load
  // lands exactly DB_CYCLES edges after the value leaves the synchroniser.
  always_comb begin
    changed = (sync2_q != prev_q);
    cnt_d   = cnt_q;
    upd_d   = 1'b0;
    if (changed) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
      upd_d = (cnt_q == CNT_MAX - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      if (upd_d) dout_q <= sync2_q;
    end
  end

  assign dout     = dout_q;
  assign dout_upd = upd_q;

endmodule

`default_nettype wire

// File: rtl/kypd_entry_ctrl.sv
// kypd_entry_ctrl: turns debounced keypad presses into numeric entries with a valid/ready output
// rev 1.0
`default_nettype none

module kypd_entry_ctrl
  import kypd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DB_CYCLES = 50000,
  parameter int HEX_MODE  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  buttons,
  output logic [4*DIGITS-1:0]          entry,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
  output logic                         key_evt,
  output logic [3:0]                   key_code,
  output logic [4*DIGITS-1:0]          out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         err
);

  localparam int            VW       = 4 * DIGITS;
  localparam int            CW       = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

  logic [15:0] db;
  logic        db_upd;

  kypd_debounce #(
    .W         (16),
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .din      (buttons),
    .dout     (db),
    .dout_upd (db_upd)
  );

  press_state_e  state_q, state_d;
  logic          evt_q, evt_d;
  logic [3:0]    code_q, code_d;
  logic [VW-1:0] entry_q, entry_d, odata_q, odata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovalid_q, ovalid_d;
  logic          err_q, err_d;
  logic          is_digit;

  // db only changes together with db_upd, so the FSM needs to look only then.
  always_comb begin
    state_d = state_q;
    evt_d   = 1'b0;
    code_d  = code_q;
    if (db_upd) begin
      case (state_q)
        IDLE: begin
          if (is_onehot(db)) begin
            state_d = PRESS;
            evt_d   = 1'b1;
            code_d  = onehot_index(db);
          end else if (db != '0) begin
            state_d = JAM;
          end
        end
        PRESS, JAM: begin
          if (db == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    is_digit = (code_q <= KEY_MAX_DEC) || ((HEX_MODE != 0) && (code_q <= KEY_MAX_HEX));
    entry_d  = entry_q;
    cnt_d    = cnt_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    err_d    = 1'b0;
    if (ovalid_q && out_ready) ovalid_d = 1'b0;
    if (evt_q) begin
      if (is_digit) begin
        if (cnt_q < CNT_FULL) begin
          entry_d = {entry_q[VW-5:0], code_q};
          cnt_d   = cnt_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else if (code_q == KEY_BACK) begin
        if (cnt_q != '0) begin
          entry_d = entry_q >> 4;
          cnt_d   = cnt_q - 1'b1;
        end
      end else if (code_q == KEY_ENTER) begin
        if (cnt_q != '0) begin
          if (!ovalid_q || out_ready) begin
            odata_d  = entry_q;
            ovalid_d = 1'b1;
            entry_d  = '0;
            cnt_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      evt_q    <= 1'b0;
      code_q   <= '0;
      entry_q  <= '0;
      cnt_q    <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      evt_q    <= evt_d;
      code_q   <= code_d;
      entry_q  <= entry_d;
      cnt_q    <= cnt_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      err_q    <= err_d;
    end
  end

  assign entry     = entry_q;
  assign digit_cnt = cnt_q;
  assign key_evt   = evt_q;
  assign key_code  = code_q;
  assign out_data  = odata_q;
  assign out_valid = ovalid_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_kypd_entry_ctrl.sv
// tb_kypd_entry_ctrl: scoreboard bench for kypd_entry_ctrl (DIGITS=4, DB_CYCLES=8, HEX_MODE=1)
// rev 1.0
`default_nettype none

module tb_kypd_entry_ctrl;

  localparam int DIGITS = 4;
  localparam int DB     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] buttons = '0;
  logic        out_ready = 1'b0;
  logic [15:0] entry, out_data;
  logic [2:0]  digit_cnt;
  logic        key_evt, out_valid, err;
  logic [3:0]  key_code;

  always #5 clk = ~clk;

  kypd_entry_ctrl #(
    .DIGITS    (DIGITS),
    .DB_CYCLES (DB),
    .HEX_MODE  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .buttons   (buttons),
    .entry     (entry),
    .digit_cnt (digit_cnt),
    .key_evt   (key_evt),
    .key_code  (key_code),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [3:0]  exp_key_q[$];
  logic [15:0] exp_out_q[$];
  bit          exp_err_q[$];
  logic [3:0]  exp_k;
  logic [15:0] exp_d;

  // Monitor: every DUT event is matched against the expected-event queues.
  always @(negedge clk) begin
    if (rst) begin
      if (key_evt) begin
        n_vec++;
        if (exp_key_q.size() == 0) begin
          n_bad++;
          $display("FAIL key_evt: unexpected event code=%h, required no event", key_code);
        end else begin
          exp_k = exp_key_q.pop_front();
          if (key_code !== exp_k) begin
            n_bad++;
            $display("FAIL key_code: got %h, required %h", key_code, exp_k);
          end
        end
      end
      if (err) begin
        n_vec++;
        if (exp_err_q.size() == 0) begin
          n_bad++;
          $display("FAIL err: unexpected err pulse, required none");
        end else begin
          void'(exp_err_q.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_out_q.size() == 0) begin
          n_bad++;
          $display("FAIL out_xfer: unexpected transfer data=%h, required none", out_data);
        end else begin
          exp_d = exp_out_q.pop_front();
          if (out_data !== exp_d) begin
            n_bad++;
            $display("FAIL out_data: got %h, required %h", out_data, exp_d);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drained(input string tag);
    check({tag, " pending keys"}, 64'(exp_key_q.size()), 64'd0);
    check({tag, " pending outs"}, 64'(exp_out_q.size()), 64'd0);
    check({tag, " pending errs"}, 64'(exp_err_q.size()), 64'd0);
  endtask

  task automatic press(input logic [3:0] k);
    buttons = 16'd1 << k;
    repeat (20) @(posedge clk);
    buttons = '0;
    repeat (20) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic check_state(input string tag, input logic [15:0] e, input logic [2:0] c);
    @(negedge clk);
    check({tag, " entry"}, 64'(entry), 64'(e));
    check({tag, " digit_cnt"}, 64'(digit_cnt), 64'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int iv[6] = '{3, 5, 2, 6, 4, 7};

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset outputs", {entry, out_data, digit_cnt, key_evt, key_code, out_valid, err}, 64'd0);

    // 1: clean 1,2,3,F with consumer always ready
    out_ready = 1'b1;
    exp_key_q.push_back(4'h1); exp_key_q.push_back(4'h2);
    exp_key_q.push_back(4'h3); exp_key_q.push_back(4'hF);
    exp_out_q.push_back(16'h0123);
    press(4'h1); press(4'h2); press(4'h3); press(4'hF);
    check_state("t1", 16'h0000, 3'd0);
    check("t1 out_valid", 64'(out_valid), 64'd0);
    drained("t1");

    // 2: bouncing key 5 yields a single event once stable
    exp_key_q.push_back(4'h5);
    for (int i = 0; i < 6; i++) begin
      buttons = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      repeat (iv[i]) @(posedge clk);
    end
    press(4'h5);
    check_state("t2", 16'h0005, 3'd1);
    drained("t2");

    // 3: chord 3+7 is ignored, then a clean 4 is accepted
    buttons = 16'h0088;
    repeat (20) @(posedge clk);
    buttons = '0;
    repeat (20) @(posedge clk);
    check_state("t3 chord", 16'h0005, 3'd1);
    exp_key_q.push_back(4'h4);
    press(4'h4);
    check_state("t3", 16'h0054, 3'd2);
    drained("t3");

    // 4: overflow on the fifth digit, then backspace
    do_reset();
    for (int k = 1; k <= 5; k++) exp_key_q.push_back(4'(k));
    exp_err_q.push_back(1'b1);
    for (int k = 1; k <= 5; k++) press(4'(k));
    check_state("t4 full", 16'h1234, 3'd4);
    exp_key_q.push_back(4'hE);
    press(4'hE);
    check_state("t4 back", 16'h0123, 3'd3);
    drained("t4");

    // 5: back-pressure, dropped enter, and enter coinciding with ready
    do_reset();
    out_ready = 1'b0;
    exp_key_q.push_back(4'hA); exp_key_q.push_back(4'h1); exp_key_q.push_back(4'hF);
    press(4'hA); press(4'h1); press(4'hF);
    check_state("t5 a1", 16'h0000, 3'd0);
    check("t5 valid a1", 64'(out_valid), 64'd1);
    check("t5 data a1", 64'(out_data), 64'h00A1);
    exp_key_q.push_back(4'h2); exp_key_q.push_back(4'h2); exp_key_q.push_back(4'hF);
    exp_err_q.push_back(1'b1);
    press(4'h2); press(4'h2); press(4'hF);
    check_state("t5 drop", 16'h0022, 3'd2);
    check("t5 data held", 64'(out_data), 64'h00A1);
    exp_key_q.push_back(4'hF);
    exp_out_q.push_back(16'h00A1);
    exp_out_q.push_back(16'h0022);
    buttons = 16'h8000;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (key_evt) seen = 1'b1;
    end
    check("t5 enter evt seen", 64'(seen), 64'd1);
    if (seen) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
    repeat (20) @(posedge clk);
    buttons = '0;
    repeat (20) @(posedge clk);
    check_state("t5 reload", 16'h0000, 3'd0);
    check("t5 valid kept", 64'(out_valid), 64'd1);
    check("t5 data 22", 64'(out_data), 64'h0022);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("t5 valid drop", 64'(out_valid), 64'd0);
    drained("t5");

    // 6: reset mid-entry with a pending output and a key held through reset
    do_reset();
    exp_key_q.push_back(4'h7); exp_key_q.push_back(4'hF);
    exp_key_q.push_back(4'h1); exp_key_q.push_back(4'h2);
    press(4'h7); press(4'hF); press(4'h1); press(4'h2);
    check_state("t6 pre", 16'h0012, 3'd2);
    check("t6 valid pre", 64'(out_valid), 64'd1);
    buttons = 16'h0200;
    repeat (3) @(posedge clk);
    do_reset();
    @(negedge clk);
    check("t6 reset outputs", {entry, out_data, digit_cnt, key_evt, key_code, out_valid, err}, 64'd0);
    exp_key_q.push_back(4'h9);
    repeat (20) @(posedge clk);
    buttons = '0;
    repeat (20) @(posedge clk);
    check_state("t6 held key", 16'h0009, 3'd1);
    drained("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
